// File: rtl/temp_bcd_conv_if.sv
// Handshake bundle between the SPI receive path and the temperature-to-BCD converter.
// The master drives raw samples and the converter (slave) returns digits and flags.
interface temp_bcd_conv_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] raw_data;
    logic              raw_valid;
    logic              busy;
    logic [15:0]       bcd_values;
    logic              neg;
    logic              ovf;
    logic              bcd_valid;

    modport master (
        output raw_data, raw_valid,
        input  busy, bcd_values, neg, ovf, bcd_valid
    );

    modport slave (
        input  raw_data, raw_valid,
        output busy, bcd_values, neg, ovf, bcd_valid
    );
endinterface

// File: rtl/temp_bcd_conv.sv
// Sequential double-dabble conversion of a signed fixed-point temperature into
// hundreds/tens/units/tenths BCD digits with sign and overflow flags.
module temp_bcd_conv #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    temp_bcd_conv_if.slave        bus
);
    localparam int INT_W = DATA_W - FRAC_BITS;
    localparam int CNT_W = $clog2(INT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   raw_q;
    logic [INT_W-1:0]    bin_q;
    logic [11:0]         bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [3:0]          tenths_q;
    logic                ovf_nx_q;
    logic                busy_q;
    logic [15:0]         bcd_values_q;
    logic                neg_q;
    logic                ovf_q;
    logic                bcd_valid_q;

    logic [DATA_W-1:0]      mag_s;
    logic [INT_W-1:0]       int_s;
    logic [FRAC_BITS+3:0]   prod_s;
    logic [3:0]             tenths_s;
    logic                   ovf_s;
    logic [11:0]            adj_s;
    logic [11:0]            bcd_d;
    logic [INT_W-1:0]       bin_d;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

    // Magnitude/fraction split of the captured word and one double-dabble step.
    always_comb begin
        mag_s    = {DATA_W{1'b0}};
        if (raw_q[DATA_W-1]) begin
            mag_s = ~raw_q + DATA_W'(1);
        end else begin
            mag_s = raw_q;
        end
        int_s    = mag_s[DATA_W-1:FRAC_BITS];
        // Truncating multiply keeps tenths in 0..9 so it never carries into units.
        prod_s   = {4'd0, mag_s[FRAC_BITS-1:0]} * (FRAC_BITS + 4)'(10);
        tenths_s = prod_s[FRAC_BITS+3:FRAC_BITS];
        ovf_s    = (int_s > INT_W'(999));
        adj_s    = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        bcd_d    = {adj_s[10:0], bin_q[INT_W-1]};
        bin_d    = {bin_q[INT_W-2:0], 1'b0};
    end

    // Conversion FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            raw_q        <= {DATA_W{1'b0}};
            bin_q        <= {INT_W{1'b0}};
            bcd_q        <= 12'h000;
            cnt_q        <= {CNT_W{1'b0}};
            tenths_q     <= 4'd0;
            ovf_nx_q     <= 1'b0;
            busy_q       <= 1'b0;
            bcd_values_q <= 16'h0000;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            bcd_valid_q  <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The bcd_valid cycle still belongs to the finished conversion.
                    if (bus.raw_valid && !bcd_valid_q) begin
                        raw_q   <= bus.raw_data;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    bin_q    <= int_s;
                    bcd_q    <= 12'h000;
                    tenths_q <= tenths_s;
                    ovf_nx_q <= ovf_s;
                    cnt_q    <= CNT_W'(INT_W);
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                DONE: begin
                    bcd_values_q <= ovf_nx_q ? 16'h9999 : {bcd_q, tenths_q};
                    neg_q        <= raw_q[DATA_W-1];
                    ovf_q        <= ovf_nx_q;
                    bcd_valid_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.bcd_values = bcd_values_q;
    assign bus.neg        = neg_q;
    assign bus.ovf        = ovf_q;
    assign bus.bcd_valid  = bcd_valid_q;
endmodule

// File: tb/tb_temp_bcd_conv.sv
// Scoreboard bench for temp_bcd_conv: directed vectors plus a model-checked sweep.
module tb_temp_bcd_conv;
    localparam int LAT = 14;

    typedef struct {
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   push_cnt = 0;
    exp_t exp_q[$];

    temp_bcd_conv_if #(.DATA_W(16)) bus ();

    temp_bcd_conv #(.DATA_W(16), .FRAC_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent arithmetic reference, no shifting or BCD tricks.
    function automatic logic [17:0] ref_model(input logic [15:0] raw);
        int mag, ip, fr, t;
        logic [15:0] b;
        mag = raw[15] ? (65536 - int'(raw)) : int'(raw);
        ip  = mag / 16;
        fr  = mag % 16;
        t   = (fr * 10) / 16;
        if (ip > 999) b = 16'h9999;
        else b = {4'((ip / 100) % 10), 4'((ip / 10) % 10), 4'(ip % 10), 4'(t)};
        return {b, raw[15], (ip > 999)};
    endfunction

    // Scoreboard monitor: compare every bcd_valid against the oldest expectation.
    always @(negedge clk) begin
        if (bus.bcd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bcd_values", {16'd0, bus.bcd_values}, {16'd0, e.bcd});
                check("neg", {31'd0, bus.neg}, {31'd0, e.neg});
                check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
                check("latency", 32'(cyc - e.cyc), 32'(LAT));
                check("busy_at_valid", {31'd0, bus.busy}, 32'd0);
            end
            done_cnt++;
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [15:0] v, input bit push,
                          input logic [15:0] b, input logic n, input logic o);
        exp_t e;
        @(negedge clk);
        bus.raw_data  = v;
        bus.raw_valid = 1'b1;
        @(negedge clk);
        bus.raw_valid = 1'b0;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        if (push) begin
            e.bcd = b; e.neg = n; e.ovf = o; e.cyc = cyc;
            exp_q.push_back(e);
            push_cnt++;
        end
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic conv(input logic [15:0] v, input logic [15:0] b, input logic n, input logic o);
        strobe(v, 1'b1, b, n, o);
        wait_done(push_cnt);
    endtask

    task automatic drive_at(input int c, input logic [15:0] v);
        while (cyc < c) @(negedge clk);
        bus.raw_data  = v;
        bus.raw_valid = 1'b1;
        @(negedge clk);
        bus.raw_valid = 1'b0;
    endtask

    initial begin
        int k;
        logic [17:0] r;
        logic [15:0] v;
        bus.raw_data  = 16'h0000;
        bus.raw_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_bcd", {16'd0, bus.bcd_values}, 32'd0);
        check("rst_neg", {31'd0, bus.neg}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_valid", {31'd0, bus.bcd_valid}, 32'd0);
        rst_n = 1'b1;

        // Reset during SHIFT discards the conversion with no bcd_valid.
        strobe(16'h0190, 1'b0, 16'h0000, 1'b0, 1'b0);
        k = cyc;
        while (cyc < k + 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_bcd", {16'd0, bus.bcd_values}, 32'd0);
        check("midrst_valid", {31'd0, bus.bcd_valid}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_valid", 32'(done_cnt), 32'd0);

        // Directed vectors.
        conv(16'h0190, 16'h0250, 1'b0, 1'b0);
        conv(16'h0198, 16'h0255, 1'b0, 1'b0);
        conv(16'h000F, 16'h0009, 1'b0, 1'b0);
        conv(16'hFE70, 16'h0250, 1'b1, 1'b0);
        conv(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        conv(16'h8000, 16'h9999, 1'b1, 1'b1);
        conv(16'h3E70, 16'h9990, 1'b0, 1'b0);
        conv(16'h3E7F, 16'h9999, 1'b0, 1'b0);
        conv(16'h3E80, 16'h9999, 1'b0, 1'b1);
        conv(16'h7FFF, 16'h9999, 1'b0, 1'b1);
        check("hold_bcd", {16'd0, bus.bcd_values}, 32'h9999);
        check("hold_ovf", {31'd0, bus.ovf}, 32'd1);

        // Strobes while busy (SHIFT, DONE, bcd_valid cycle) are dropped.
        strobe(16'h0190, 1'b1, 16'h0250, 1'b0, 1'b0);
        k = cyc;
        drive_at(k + 5, 16'h0320);
        drive_at(k + 13, 16'h0320);
        drive_at(k + 14, 16'h0320);
        wait_done(push_cnt);
        repeat (20) @(negedge clk);
        check("drop_single_valid", 32'(done_cnt), 32'(push_cnt));
        conv(16'h0320, 16'h0500, 1'b0, 1'b0);

        // Back-to-back sweep against the reference model.
        for (int i = 0; i < 60; i++) begin
            v = 16'((i * 1657 + 13) & 16'hFFFF);
            r = ref_model(v);
            conv(v, r[17:2], r[1], r[0]);
        end

        repeat (20) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("valid_count", 32'(done_cnt), 32'(push_cnt));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
